// File: rtl/seq_divider32.sv
// Multicycle restoring divider (DIV/DIVU): one trial subtraction per clock, quotient to LO, remainder to HI.
// Optional build macro SEQ_DIVIDER32_ABORT_EN adds an abort input that cancels a running divide.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER32_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQ_DIVIDER32_ABORT_EN
    logic             dbz_save_q, dbz_save_d;
`endif

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic             qbit_c;
    logic [WIDTH-1:0] q_mag_c;
    logic [WIDTH-1:0] r_mag_c;

    // Trial subtraction at WIDTH+1 bits; the MSB is the borrow / sign of the trial.
    assign shifted_c = {prem_q, dvd_q[WIDTH-1]};
    assign trial_c   = shifted_c - {1'b0, dvs_q};
    assign qbit_c    = ~trial_c[WIDTH];
    assign q_mag_c   = {dvd_q[WIDTH-2:0], qbit_c};
    assign r_mag_c   = qbit_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
`ifdef SEQ_DIVIDER32_ABORT_EN
        dbz_save_d = dbz_save_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvs_d     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    prem_d    = '0;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dbz_d     = 1'b0;
`ifdef SEQ_DIVIDER32_ABORT_EN
                    dbz_save_d = dbz_q;
`endif
                    if (divisor == '0) begin
                        // Remainder reports the raw dividend, not its magnitude.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                prem_d = r_mag_c;
                dvd_d  = q_mag_c;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quo_d   = neg_quo_q ? -q_mag_c : q_mag_c;
                    rem_d   = neg_rem_q ? -r_mag_c : r_mag_c;
                    state_d = DONE;
                end
`ifdef SEQ_DIVIDER32_ABORT_EN
                if (abort) begin
                    quo_d   = quo_q;
                    rem_d   = rem_q;
                    dbz_d   = dbz_save_q;
                    state_d = IDLE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_DIVIDER32_ABORT_EN
            dbz_save_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_DIVIDER32_ABORT_EN
            dbz_save_q <= dbz_save_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32 (WIDTH=32); covers the abort input when SEQ_DIVIDER32_ABORT_EN is defined.
module tb_seq_divider32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
`ifdef SEQ_DIVIDER32_ABORT_EN
    logic        abort;
`endif

    int n_vec = 0;
    int n_err = 0;
    int lat;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER32_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation at edge E0, scramble the operand inputs, then wait (bounded) for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        step();
        start     = 1'b0;
        dividend  = ~a;
        divisor   = ~b;
        is_signed = ~s;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_lat,
                                input logic [31:0] q, input logic [31:0] r, input logic z);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_quo"}, quotient, q);
        chk({tag, "_rem"}, remainder, r);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef SEQ_DIVIDER32_ABORT_EN
        abort     = 1'b0;
`endif
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quo",  quotient,  32'd0);
        chk("rst_rem",  remainder, 32'd0);
        chk("rst_dbz",  32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        step();

        // Unsigned 100/7: done seen 32 edges after E0 (33 edges total).
        run_op(32'd100, 32'd7, 1'b0, lat);
        check_result("u100_7", lat, 32, 32'd14, 32'd2, 1'b0);
        chk("u100_7_busy_at_done", 32'(busy), 32'd1);
        step();
        chk("u100_7_done_drop", 32'(done), 32'd0);
        chk("u100_7_busy_drop", 32'(busy), 32'd0);
        chk("u100_7_hold_quo", quotient, 32'd14);
        step();

        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        check_result("s_m7_2", lat, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        step();

        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
        check_result("s_7_m2", lat, 32, 32'hFFFF_FFFD, 32'd1, 1'b0);
        step();

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        check_result("s_ovf", lat, 32, 32'h8000_0000, 32'd0, 1'b0);
        step();

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        check_result("u_big", lat, 32, 32'd0, 32'h8000_0000, 1'b0);
        step();

        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        check_result("u_max_1", lat, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
        step();

        // Divide by zero, then a start held during the done cycle must be ignored.
        run_op(32'h1234_5678, 32'd0, 1'b1, lat);
        check_result("dbz", lat, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        chk("dbz_hold", 32'(div_by_zero), 32'd1);
        step();

        // Next accepted start clears div_by_zero.
        run_op(32'd9, 32'd3, 1'b0, lat);
        check_result("u9_3", lat, 32, 32'd3, 32'd0, 1'b0);
        step();

        // Start 100/7, re-pulse start at E5, assert reset at E10.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("repulse_busy", 32'(busy), 32'd1);
        for (int e = 6; e <= 9; e++) step();
        chk("pre_reset_done", 32'(done), 32'd0);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", 32'(busy), 32'd0);
        chk("midop_rst_done", 32'(done), 32'd0);
        chk("midop_rst_quo",  quotient,  32'd0);
        chk("midop_rst_rem",  remainder, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op(32'd9, 32'd3, 1'b0, lat);
        check_result("post_rst_9_3", lat, 32, 32'd3, 32'd0, 1'b0);
        step();

`ifdef SEQ_DIVIDER32_ABORT_EN
        // Abort sampled at E10 cancels; previous 9/3 results remain.
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int e = 1; e <= 9; e++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        begin
            int seen_done = 0;
            for (int e = 0; e < 40; e++) begin
                if (done === 1'b1) seen_done++;
                step();
            end
            chk("abort_no_done", 32'(seen_done), 32'd0);
        end
        chk("abort_quo", quotient, 32'd3);
        chk("abort_rem", remainder, 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
